// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking lot barrier gate controller.
package parking_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OPEN = 2'd1,
      S_HOLD = 2'd2
   } gate_state_e;

   localparam int unsigned DEF_CAPACITY   = 8;
   localparam int unsigned DEF_CNT_W      = 4;
   localparam int unsigned DEF_OPEN_TICKS = 50;
   localparam int unsigned DEF_HOLD_TICKS = 10;

   // Width needed to hold the larger of the two phase lengths.
   function automatic int unsigned timer_w(input int unsigned open_t,
                                           input int unsigned hold_t);
      int unsigned m;
      m = (open_t > hold_t) ? open_t : hold_t;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/parking_gate_ctrl_timer.sv
// Loadable down-counter pacing the OPEN and HOLD phases of the gate.
module gate_timer #(
   parameter int unsigned W = 6
) (
   input  logic         NewCLK,
   input  logic         RST,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         done
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge NewCLK) begin
      if (!RST) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_value;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   // Last cycle of the loaded interval, or idle at zero.
   assign done = (cnt_q <= W'(1));

endmodule

// File: rtl/parking_gate_ctrl.sv
// Barrier gate sequencer: entry/exit arbitration, pending latches, occupancy and lamp.
module parking_gate_ctrl
   import parking_pkg::*;
#(
   parameter int unsigned CAPACITY   = DEF_CAPACITY,
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned OPEN_TICKS = DEF_OPEN_TICKS,
   parameter int unsigned HOLD_TICKS = DEF_HOLD_TICKS
) (
   input  logic             NewCLK,
   input  logic             RST,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             car_passed,
   output logic             gate_open,
   output logic             dir_in,
   output logic [CNT_W-1:0] count,
   output logic             lamp_full,
   output logic             reject,
   output logic             timeout
);

   localparam int unsigned      TW    = timer_w(OPEN_TICKS, HOLD_TICKS);
   localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

   gate_state_e      state_q;
   logic             pend_in_q;
   logic             pend_out_q;
   logic [CNT_W-1:0] count_q;
   logic             gate_open_q;
   logic             dir_in_q;
   logic             lamp_full_q;
   logic             reject_q;
   logic             timeout_q;

   logic             want_in;
   logic             want_out;
   logic             lot_empty;
   logic             lot_full;
   logic             grant_any;
   logic             passed;
   logic [CNT_W-1:0] count_d;
   logic             tmr_load;
   logic [TW-1:0]    tmr_value;
   logic             tmr_done;

   always_comb begin
      want_in   = pend_in_q | entry_req;
      want_out  = pend_out_q | exit_req;
      lot_empty = (count_q == '0);
      lot_full  = (count_q == CAP_C);
      grant_any = 1'b0;
      if (state_q == S_IDLE) begin
         if (want_out) begin
            grant_any = !lot_empty;
         end else if (want_in) begin
            grant_any = !lot_full;
         end
      end
      passed    = (state_q == S_OPEN) && car_passed;
      count_d   = dir_in_q ? (count_q + CNT_W'(1)) : (count_q - CNT_W'(1));
      tmr_load  = grant_any | passed;
      tmr_value = passed ? TW'(HOLD_TICKS) : TW'(OPEN_TICKS);
   end

   gate_timer #(
      .W(TW)
   ) u_timer (
      .NewCLK     (NewCLK),
      .RST        (RST),
      .load       (tmr_load),
      .load_value (tmr_value),
      .done       (tmr_done)
   );

   always_ff @(posedge NewCLK) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         pend_in_q   <= 1'b0;
         pend_out_q  <= 1'b0;
         count_q     <= '0;
         gate_open_q <= 1'b0;
         dir_in_q    <= 1'b0;
         lamp_full_q <= 1'b0;
         reject_q    <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         reject_q   <= 1'b0;
         timeout_q  <= 1'b0;
         pend_in_q  <= pend_in_q | entry_req;
         pend_out_q <= pend_out_q | exit_req;
         case (state_q)
            S_IDLE: begin
               // Exit has priority; only one request is resolved per cycle.
               if (want_out) begin
                  pend_out_q <= 1'b0;
                  if (lot_empty) begin
                     reject_q <= 1'b1;
                  end else begin
                     dir_in_q    <= 1'b0;
                     gate_open_q <= 1'b1;
                     state_q     <= S_OPEN;
                  end
               end else if (want_in) begin
                  pend_in_q <= 1'b0;
                  if (lot_full) begin
                     reject_q <= 1'b1;
                  end else begin
                     dir_in_q    <= 1'b1;
                     gate_open_q <= 1'b1;
                     state_q     <= S_OPEN;
                  end
               end
            end
            S_OPEN: begin
               if (passed) begin
                  count_q     <= count_d;
                  lamp_full_q <= (count_d == CAP_C);
                  state_q     <= S_HOLD;
               end else if (tmr_done) begin
                  timeout_q   <= 1'b1;
                  gate_open_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            S_HOLD: begin
               if (tmr_done) begin
                  gate_open_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               gate_open_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign gate_open = gate_open_q;
   assign dir_in    = dir_in_q;
   assign count     = count_q;
   assign lamp_full = lamp_full_q;
   assign reject    = reject_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed and randomized transactions checked against an occupancy/timing model.
module tb_parking_gate_ctrl;

   localparam int CAP = 8;
   localparam int OT  = 50;
   localparam int HT  = 10;

   logic       NewCLK = 1'b0;
   logic       RST = 1'b0;
   logic       entry_req = 1'b0;
   logic       exit_req = 1'b0;
   logic       car_passed = 1'b0;
   logic       gate_open;
   logic       dir_in;
   logic [3:0] count;
   logic       lamp_full;
   logic       reject;
   logic       timeout;

   int total = 0;
   int bad   = 0;
   int occ   = 0;

   parking_gate_ctrl #(
      .CAPACITY   (CAP),
      .CNT_W      (4),
      .OPEN_TICKS (OT),
      .HOLD_TICKS (HT)
   ) dut (
      .NewCLK     (NewCLK),
      .RST        (RST),
      .entry_req  (entry_req),
      .exit_req   (exit_req),
      .car_passed (car_passed),
      .gate_open  (gate_open),
      .dir_in     (dir_in),
      .count      (count),
      .lamp_full  (lamp_full),
      .reject     (reject),
      .timeout    (timeout)
   );

   always #5 NewCLK = ~NewCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge NewCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gate"}, gate_open, 0);
      chk({tag, "_dir"}, dir_in, 0);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_lamp"}, lamp_full, 0);
      chk({tag, "_reject"}, reject, 0);
      chk({tag, "_timeout"}, timeout, 0);
   endtask

   // Called right after the edge on which a grant was made. d==0: car never passes.
   task automatic serve(input bit is_entry, input int d, input bit inject);
      chk("grant_gate", gate_open, 1);
      chk("grant_dir", dir_in, is_entry);
      chk("grant_reject", reject, 0);
      if (d == 0) begin
         for (int i = 1; i < OT; i++) begin
            tick();
            chk("open_wait", {gate_open, timeout}, 2'b10);
         end
         tick();
         chk("to_gate", gate_open, 0);
         chk("to_pulse", timeout, 1);
         chk("to_count", count, occ);
         tick();
         chk("to_pulse_end", timeout, 0);
      end else begin
         for (int i = 1; i < d; i++) begin
            tick();
            chk("open_wait", {gate_open, timeout}, 2'b10);
            chk("open_count", count, occ);
         end
         car_passed = 1'b1;
         tick();
         car_passed = 1'b0;
         occ = is_entry ? occ + 1 : occ - 1;
         chk("pass_count", count, occ);
         chk("pass_full", lamp_full, (occ == CAP));
         chk("hold_gate", gate_open, 1);
         for (int i = 1; i < HT; i++) begin
            if (inject && (i == 2 || i == 5)) entry_req = 1'b1;
            if (i == 3) car_passed = 1'b1;
            tick();
            entry_req  = 1'b0;
            car_passed = 1'b0;
            chk("hold_gate", gate_open, 1);
         end
         tick();
         chk("close_gate", gate_open, 0);
         chk("close_timeout", timeout, 0);
         chk("hold_ignore_count", count, occ);
      end
   endtask

   task automatic request(input bit is_entry, input int d, input bit inject);
      if (is_entry) entry_req = 1'b1;
      else exit_req = 1'b1;
      tick();
      entry_req = 1'b0;
      exit_req  = 1'b0;
      if ((is_entry && occ == CAP) || (!is_entry && occ == 0)) begin
         chk("rej_pulse", reject, 1);
         chk("rej_gate", gate_open, 0);
         chk("rej_count", count, occ);
         tick();
         chk("rej_pulse_end", reject, 0);
         chk("rej_gate_after", gate_open, 0);
      end else begin
         serve(is_entry, d, inject);
      end
   endtask

   initial begin
      bit ent;
      int d;

      RST = 1'b0;
      tick();
      tick();
      chk_reset_outputs("reset");
      RST = 1'b1;
      tick();

      request(1, 5, 0);
      chk("first_entry_count", count, 1);

      for (int k = 0; k < CAP - 1; k++) request(1, $urandom_range(1, OT), 0);
      chk("filled_count", count, CAP);
      chk("filled_lamp", lamp_full, 1);
      request(1, 5, 0);
      chk("full_reject_lamp", lamp_full, 1);
      chk("full_reject_count", count, CAP);

      for (int k = 0; k < 5; k++) request(0, $urandom_range(1, OT), 0);
      chk("drained_count", count, 3);

      entry_req = 1'b1;
      exit_req  = 1'b1;
      tick();
      entry_req = 1'b0;
      exit_req  = 1'b0;
      serve(0, $urandom_range(1, OT), 0);
      chk("both_exit_count", count, 2);
      tick();
      serve(1, $urandom_range(1, OT), 0);
      chk("both_entry_count", count, 3);

      request(1, 0, 0);
      chk("timeout_count", count, 3);

      car_passed = 1'b1;
      tick();
      car_passed = 1'b0;
      chk("idle_car_count", count, 3);
      chk("idle_car_gate", gate_open, 0);

      for (int k = 0; k < 3; k++) request(0, $urandom_range(1, OT), 0);
      request(0, 5, 0);
      chk("empty_reject_count", count, 0);

      request(1, OT, 0);
      chk("boundary_pass_count", count, 1);
      request(0, $urandom_range(1, OT), 1);
      tick();
      serve(1, $urandom_range(1, OT), 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("no_dup_grant", gate_open, 0);
      end

      for (int k = 0; k < 40; k++) begin
         ent = 1'($urandom_range(0, 1));
         d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, OT);
         request(ent, d, 0);
      end
      chk("random_count", count, occ);
      chk("random_lamp", lamp_full, (occ == CAP));

      if (occ == CAP) request(0, 3, 0);
      entry_req = 1'b1;
      tick();
      entry_req = 1'b0;
      chk("rst_test_grant", gate_open, 1);
      tick();
      entry_req = 1'b1;
      tick();
      entry_req = 1'b0;
      RST = 1'b0;
      car_passed = 1'b1;
      tick();
      car_passed = 1'b0;
      RST = 1'b1;
      occ = 0;
      chk_reset_outputs("mid_rst");
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("post_rst_gate", gate_open, 0);
         chk("post_rst_reject", reject, 0);
         chk("post_rst_count", count, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
Controller for the single shared barrier gate of the parking lot. It takes one-cycle entry and exit request pulses from the debounced, edge-detected button/sensor front-end. It arbitrates between the entry and exit requesters and sequences the gate through open, pass and hold phases. It also keeps the occupancy count and drives the full lamp.

Parameters:
CAPACITY, 8, number of parking spaces (1..15)
CNT_W, 4, width of occupancy count; must hold CAPACITY
OPEN_TICKS, 50, NewCLK cycles to wait for car_passed before the gate aborts
HOLD_TICKS, 10, NewCLK cycles the gate stays open after car_passed

Ports:
NewCLK  in  1  system clock
RST  in  1  reset, synchronous, active-low
entry_req  in  1  one-cycle pulse, car requests entry
exit_req  in  1  one-cycle pulse, car requests exit
car_passed  in  1  one-cycle pulse from beam sensor, car cleared gate
gate_open  out  1  barrier open command
dir_in  out  1  1 = current/last grant is entry, 0 = exit
count  out  CNT_W  occupied spaces
lamp_full  out  1  count == CAPACITY
reject  out  1  one-cycle pulse, request refused (full lot, or empty lot on exit)
timeout  out  1  one-cycle pulse, OPEN phase expired without car_passed

Behaviour:
- Reset is synchronous and active-low: RST sampled low at a NewCLK edge forces state IDLE.
  - count=0, pending_in=0, pending_out=0, timer=0.
  - gate_open=0, dir_in=0, reject=0, timeout=0; lamp_full=0 (since CAPACITY >= 1).
- RST low mid-operation discards any in-flight car: no count change, gate closes next edge.
- Pending latches: an entry_req/exit_req pulse sets pending_in/pending_out in any state.
  - A latch is cleared only when its request is granted or rejected. Duplicate pulses collapse into the one pending request.
  - In IDLE, a same-cycle pulse is treated as pending immediately (combinational OR with the latch).
- States and transitions:
  - IDLE: if exit pending -> exit wins arbitration (frees a space).
    - count==0: reject pulse, clear pending_out, stay IDLE.
    - Otherwise: grant, dir_in=0, load timer=OPEN_TICKS, go OPEN, clear pending_out.
  - IDLE, entry pending and no exit pending:
    - count==CAPACITY: reject pulse, clear pending_in.
    - Otherwise: grant, dir_in=1, go OPEN, clear pending_in.
  - IDLE, one request handled per cycle: if both are pending and exit is rejected, entry is evaluated on the next cycle.
  - OPEN: gate_open=1.
    - car_passed: count +1 if dir_in else -1, load timer=HOLD_TICKS, go HOLD.
    - Else timer reaches 1 (OPEN_TICKS cycles elapsed): timeout pulse, go IDLE, no count change.
    - If car_passed and timer expiry coincide, car_passed wins.
  - HOLD: gate_open=1; car_passed is ignored; after HOLD_TICKS cycles go IDLE.
  - car_passed in IDLE is ignored.
- Latency: a request pulse at edge N in IDLE gives gate_open=1 at N+1. count updates on the edge after car_passed is sampled. gate_open falls exactly HOLD_TICKS cycles after HOLD entry.
- All outputs are registered; reject and timeout are high for exactly one cycle.
- count never wraps: increments are blocked by the full check at grant time, decrements by the empty check. count only changes in OPEN, so the grant-time check is exact.
- lamp_full is registered from the next value of count.

Decomposition:
- Package parking_pkg holds:
  - state encoding IDLE/OPEN/HOLD as a 2-bit typedef;
  - default CAPACITY, OPEN_TICKS and HOLD_TICKS constants;
  - timer width function clog2(max(OPEN_TICKS, HOLD_TICKS)+1).
- One natural sub-module, gate_timer: loadable down-counter with load, load_value and a done flag (count==1 after load, or zero). It has the same NewCLK/RST reset.
- Arbitration, pending latches and the occupancy counter stay in parking_gate_ctrl.

Test Plan:
- Reset, then entry_req, then car_passed 5 cycles later:
  - gate_open rises 1 cycle after the request;
  - count 0->1 the cycle after car_passed;
  - gate_open falls after 10 more cycles.
- Fill to CAPACITY=8 via 8 entry cycles, then entry_req: lamp_full=1, reject pulses once, gate_open stays 0, count stays 8.
- In IDLE with count=3, entry_req and exit_req in the same cycle:
  - exit is served first; count 3->2 after car_passed;
  - the pending entry is then served automatically; count back to 3.
- entry_req with no car_passed: after 50 cycles a timeout pulse, gate_open=0, count unchanged. exit_req at count=0 gives a reject pulse.
- entry_req pulse during HOLD of a prior exit: latched, granted on the first cycle back in IDLE. A second duplicate pulse does not cause a second grant.
- RST low during OPEN with car_passed in the same cycle: next cycle all outputs return to reset values, count=0, pending latches cleared.
